// File: rtl/prescaled_counter.sv
// prescaled_counter
//
// Purpose:
//    An up/down counter that advances one step every (i_prescale + 1) enabled
//    clock cycles. At the terminal value it either wraps or saturates. It
//    emits a one-cycle tick for every step and a one-cycle terminal-count
//    pulse for every step taken while the count sits at the terminal value.
//    All outputs are registered, so no input reaches an output
//    combinationally.
//
// Configuration:
//    PRESCALED_COUNTER_PRESCALER_EN
//       Defined   : the internal prescale counter is built, and i_prescale
//                   sets the divisor.
//       Undefined : no prescaler is built, every enabled cycle is a step,
//                   and i_prescale is ignored.
//
// Parameters:
//    BIT_WIDTH       width of the count output (default 14)
//    PRESCALE_WIDTH  width of the prescale divisor input (default 16)
//
// Ports:
//    i_clk           single clock; all state updates on its rising edge
//    i_rst           synchronous active-high reset
//    i_en            count enable; the prescaler advances only while high
//    i_dir           count direction, 1 = up, 0 = down
//    i_mode          terminal behaviour, 0 = wrap, 1 = saturate
//    i_load          synchronous load strobe
//    i_load_value    value taken by the count on load
//    i_prescale      divisor minus one
//    o_count_output  registered count value
//    o_tick          registered one-cycle pulse per count step
//    o_tc            registered one-cycle terminal-count pulse

module prescaled_counter #(
   parameter int BIT_WIDTH      = 14,
   parameter int PRESCALE_WIDTH = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_en,
   input  logic                      i_dir,
   input  logic                      i_mode,
   input  logic                      i_load,
   input  logic [BIT_WIDTH-1:0]      i_load_value,
   input  logic [PRESCALE_WIDTH-1:0] i_prescale,
   output logic [BIT_WIDTH-1:0]      o_count_output,
   output logic                      o_tick,
   output logic                      o_tc
);

   localparam logic [BIT_WIDTH-1:0] COUNT_MAX = {BIT_WIDTH{1'b1}};
   localparam logic [BIT_WIDTH-1:0] COUNT_MIN = '0;

   logic stepNow;
   logic atTerminal;

`ifdef PRESCALED_COUNTER_PRESCALER_EN

   logic [PRESCALE_WIDTH-1:0] pscCount;

   // A step fires once the prescale counter has reached the divisor. The
   // comparison is >= rather than ==, so if software lowers i_prescale below
   // the current partial count, the next enabled cycle steps immediately
   // instead of running all the way around the counter.
   always_comb begin
      stepNow = i_en && (pscCount >= i_prescale);
   end

   // The prescale counter restarts on reset, on load and on every step.
   // Otherwise it counts enabled cycles, and it freezes while the enable is
   // low, so the divisor counts enabled cycles rather than wall-clock cycles.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pscCount <= '0;
      end else if (i_load) begin
         pscCount <= '0;
      end else if (stepNow) begin
         pscCount <= '0;
      end else if (i_en) begin
         pscCount <= pscCount + 1'b1;
      end
   end

`else

   logic unusedPrescale;

   // With no prescaler, every enabled cycle is a step. i_prescale is folded
   // into a named dummy so the unused input stays visible in the netlist.
   always_comb begin
      stepNow        = i_en;
      unusedPrescale = ^i_prescale;
   end

`endif

   // The terminal value depends on the direction currently requested: the
   // all-ones value when counting up and zero when counting down. It is
   // re-evaluated each cycle, so a direction change applies to the next step.
   always_comb begin
      atTerminal = i_dir ? (o_count_output == COUNT_MAX)
                         : (o_count_output == COUNT_MIN);
   end

   // Main count register, updated in priority order: reset, then load, then
   // step. A load suppresses both pulses, even when a step would otherwise
   // have qualified. On a step at the terminal value, saturate mode holds the
   // count. Wrap mode relies on the natural modulo-2^BIT_WIDTH overflow of the
   // add and subtract. The tick and terminal-count pulses are registered
   // alongside the count, so they line up with the updated value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_count_output <= '0;
         o_tick         <= 1'b0;
         o_tc           <= 1'b0;
      end else if (i_load) begin
         o_count_output <= i_load_value;
         o_tick         <= 1'b0;
         o_tc           <= 1'b0;
      end else begin
         o_tick <= stepNow;
         o_tc   <= stepNow && atTerminal;
         if (stepNow && !(atTerminal && i_mode)) begin
            if (i_dir) begin
               o_count_output <= o_count_output + 1'b1;
            end else begin
               o_count_output <= o_count_output - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_prescaled_counter.sv
// tb_prescaled_counter
//
// Purpose:
//    Self-checking bench for prescaled_counter with BIT_WIDTH = 4. A
//    behavioural model tracks the count as a plain integer together with the
//    number of enabled cycles since the last step. Directed scenarios are
//    checked against literal values, and a long randomized run is checked
//    against the model.

module tb_prescaled_counter;

   localparam int BW     = 4;
   localparam int PW     = 4;
   localparam int TOPVAL = (1 << BW) - 1;

   logic          clk;
   logic          rst;
   logic          en;
   logic          dir;
   logic          mode;
   logic          load;
   logic [BW-1:0] loadValue;
   logic [PW-1:0] prescale;
   logic [BW-1:0] countOut;
   logic          tick;
   logic          tc;

   int compared;
   int mismatched;

   int modelCount;
   int modelPsc;
   int modelTick;
   int modelTc;

   prescaled_counter #(
      .BIT_WIDTH      (BW),
      .PRESCALE_WIDTH (PW)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_en           (en),
      .i_dir          (dir),
      .i_mode         (mode),
      .i_load         (load),
      .i_load_value   (loadValue),
      .i_prescale     (prescale),
      .o_count_output (countOut),
      .o_tick         (tick),
      .o_tc           (tc)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it when the observed value differs
   // from the expected one.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      compared++;
      if (observed != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d at time %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle of inputs and advances the model according to the
   // counter's rules. It then clocks the DUT and compares all three outputs
   // against the model 1 time unit after the edge.
   task automatic applyStimulus(input logic r, input logic e, input logic d, input logic m,
                                input logic l, input int lv, input int ps);
      bit step;
      bit terminal;
      rst       = r;
      en        = e;
      dir       = d;
      mode      = m;
      load      = l;
      loadValue = lv[BW-1:0];
      prescale  = ps[PW-1:0];
`ifdef PRESCALED_COUNTER_PRESCALER_EN
      step = e && (modelPsc >= ps);
`else
      step = e;
`endif
      terminal = d ? (modelCount == TOPVAL) : (modelCount == 0);
      if (r) begin
         modelCount = 0;
         modelPsc   = 0;
         modelTick  = 0;
         modelTc    = 0;
      end else if (l) begin
         modelCount = lv;
         modelPsc   = 0;
         modelTick  = 0;
         modelTc    = 0;
      end else begin
         modelTick = step ? 1 : 0;
         modelTc   = (step && terminal) ? 1 : 0;
         if (step) begin
            modelPsc = 0;
            if (!(terminal && m)) begin
               modelCount = d ? (modelCount + 1) % (TOPVAL + 1)
                              : (modelCount + TOPVAL) % (TOPVAL + 1);
            end
         end else if (e) begin
            modelPsc = modelPsc + 1;
         end
      end
      @(posedge clk);
      #1;
      checkOutput("count", int'(countOut), modelCount);
      checkOutput("tick", int'(tick), modelTick);
      checkOutput("tc", int'(tc), modelTc);
   endtask

   // Directed scenarios first, then a randomized run against the model.
   initial begin
      int expectSeq[9];
      int ps;
      logic d;
      logic m;
      compared   = 0;
      mismatched = 0;
      modelCount = 0;
      modelPsc   = 0;
      modelTick  = 0;
      modelTc    = 0;
      rst = 1'b1; en = 1'b0; dir = 1'b1; mode = 1'b0;
      load = 1'b0; loadValue = '0; prescale = '0;
      #1;

      applyStimulus(1, 0, 1, 0, 0, 0, 0);
      checkOutput("resetCount", int'(countOut), 0);
      checkOutput("resetTick", int'(tick), 0);
      checkOutput("resetTc", int'(tc), 0);

`ifdef PRESCALED_COUNTER_PRESCALER_EN
      expectSeq = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 0, 2);
         checkOutput("prescaleSeq", int'(countOut), expectSeq[i]);
      end
`else
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 0, 7);
         checkOutput("noPscCount", int'(countOut), i + 1);
         checkOutput("noPscTick", int'(tick), 1);
      end
`endif

      applyStimulus(0, 0, 1, 0, 1, 15, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      checkOutput("wrapCount", int'(countOut), 0);
      checkOutput("wrapTc", int'(tc), 1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkOutput("wrapTcOnce", int'(tc), 0);

      applyStimulus(0, 0, 0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 1, 0, 0, 0);
         checkOutput("satCount", int'(countOut), 0);
         checkOutput("satTc", int'(tc), 1);
      end

      applyStimulus(0, 1, 1, 0, 1, 9, 0);
      checkOutput("loadCount", int'(countOut), 9);
      checkOutput("loadTick", int'(tick), 0);

`ifdef PRESCALED_COUNTER_PRESCALER_EN
      applyStimulus(0, 0, 1, 0, 1, 5, 3);
      applyStimulus(0, 1, 1, 0, 0, 0, 3);
      applyStimulus(1, 1, 1, 0, 0, 0, 3);
      checkOutput("rstMidCount", int'(countOut), 0);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 0, 3);
         checkOutput("rstMidTick", int'(tick), (i == 4) ? 1 : 0);
      end
`endif

      ps = 1; d = 1'b1; m = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(29) == 0) ps = $urandom_range(5);
         if ($urandom_range(9) == 0) d = ~d;
         if ($urandom_range(9) == 0) m = ~m;
         applyStimulus(($urandom_range(49) == 0), ($urandom_range(3) != 0), d, m,
                       ($urandom_range(19) == 0), $urandom_range(TOPVAL), ps);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 SHALL provide parameter BIT_WIDTH, default 14: width of the count output.
REQ-002 SHALL provide parameter PRESCALE_WIDTH, default 16: width of the prescale divisor input.
REQ-003 SHALL provide port i_clk, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-004 SHALL provide port i_rst, input, 1 bit: synchronous reset, active-high.
REQ-005 SHALL provide port i_en, input, 1 bit: count enable; the prescaler advances only while high.
REQ-006 SHALL provide port i_dir, input, 1 bit: count direction; 1 = up, 0 = down.
REQ-007 SHALL provide port i_mode, input, 1 bit: terminal behaviour; 0 = wrap, 1 = saturate.
REQ-008 SHALL provide port i_load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL provide port i_load_value, input, BIT_WIDTH bits: value applied on load.
REQ-010 SHALL provide port i_prescale, input, PRESCALE_WIDTH bits: divisor minus 1; a step occurs every i_prescale+1 enabled cycles.
REQ-011 SHALL provide port o_count_output, output, BIT_WIDTH bits: registered count value.
REQ-012 SHALL provide port o_tick, output, 1 bit: registered one-cycle pulse per count step.
REQ-013 SHALL provide port o_tc, output, 1 bit: registered one-cycle terminal-count pulse.

Function
REQ-014 SHALL keep an internal prescale counter psc of PRESCALE_WIDTH bits.
REQ-015 SHALL define step = i_en AND (psc >= i_prescale); the >= comparison makes a mid-count reduction of i_prescale step on the next enabled cycle.
REQ-016 On step, psc SHALL clear to 0; when i_en is high without a step, psc SHALL increment; when i_en is low, psc SHALL hold.
REQ-017 i_prescale = 0 SHALL produce a step on every enabled cycle.
REQ-018 Update priority SHALL be: i_rst, then i_load, then step.
REQ-019 On i_load, o_count_output SHALL take i_load_value at the next edge, psc SHALL clear to 0, and o_tick and o_tc SHALL be 0 for that cycle, regardless of i_en.
REQ-020 On a step with i_dir = 1, count SHALL increment; at 2^BIT_WIDTH-1 it SHALL go to 0 (i_mode = 0) or hold (i_mode = 1).
REQ-021 On a step with i_dir = 0, count SHALL decrement; at 0 it SHALL go to 2^BIT_WIDTH-1 (i_mode = 0) or hold (i_mode = 1).
REQ-022 o_tick SHALL register step, i.e. be high in the cycle after a qualifying edge, coincident with the updated count.
REQ-023 o_tc SHALL register (step AND count at the terminal for the current i_dir), in both wrap and saturate modes; in saturate mode it therefore pulses on every step taken while at the terminal.
REQ-024 Count latency SHALL be one cycle from the step-qualifying edge; there SHALL be no combinational path from any input to any output.
REQ-025 Changing i_dir or i_mode SHALL take effect on the next step, with no effect on psc.

Reset
REQ-026 While i_rst is high at an edge, o_count_output, psc, o_tick and o_tc SHALL all become 0, overriding i_load and i_en.
REQ-027 Reset asserted mid-prescale SHALL discard the partial psc count; after release, the first step SHALL occur i_prescale+1 enabled cycles later.

Configuration
REQ-028 Macro PRESCALED_COUNTER_PRESCALER_EN defined: the prescaler SHALL be built and behave as in REQ-014 to REQ-017.
REQ-029 Macro PRESCALED_COUNTER_PRESCALER_EN undefined: psc SHALL NOT be built, step SHALL equal i_en, and i_prescale SHALL be ignored; all other requirements SHALL be unchanged.

Verification (BIT_WIDTH=4, macro defined unless noted)
REQ-030 Prescale: i_prescale=2, up, i_en high for 9 cycles from 0 -> count 0,0,1,1,1,2,2,2,3 at successive cycles; o_tick pulses 3 times, 3 cycles apart.
REQ-031 Wrap: load 15, i_prescale=0, up, wrap, i_en high for 1 cycle -> count 0 and o_tc=1 for exactly one cycle.
REQ-032 Saturate down: load 0, down, saturate, i_prescale=0, i_en high for 3 cycles -> count stays 0 and o_tc=1 for 3 cycles.
REQ-033 Load vs step: i_load=1 with i_load_value=9 in the same cycle as a qualifying step -> count 9, o_tick=0, psc=0.
REQ-034 Reset mid-run: count 5 with psc=1 and i_prescale=3, i_rst pulsed -> all outputs 0; after release with i_en held high, the first o_tick occurs 4 cycles later.
REQ-035 Macro undefined: i_prescale=7, i_en high for 4 cycles -> count 1,2,3,4 and o_tick high every cycle.
